// File: rtl/sd_decimator_pkg.sv
// Shared definitions for the sigma-delta decimator.
// Holds the CIC datapath widths, the minimum decimation ratio, the comb
// sequencer state encoding and two helpers: effective ratio decode and
// output saturation.
package sd_pkg;

    localparam int CIC_WIDTH = 26;
    localparam int PCM_WIDTH = 24;
    localparam int CIC_ORDER = 3;
    localparam int R_MIN     = 4;

    // Saturation bounds expressed at CIC width for direct comparison.
    localparam logic signed [CIC_WIDTH-1:0] SAT_HI = 26'sd8388607;
    localparam logic signed [CIC_WIDTH-1:0] SAT_LO = -26'sd8388608;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_C1   = 3'd1,
        SEQ_C2   = 3'd2,
        SEQ_C3   = 3'd3,
        SEQ_OUT  = 3'd4
    } seqState_t;

    // Decimation ratio decode: 0 means 256, anything below R_MIN clamps up.
    function automatic logic [8:0] effRatio(input logic [7:0] r);
        if (r == 8'd0) begin
            return 9'd256;
        end else if (r < 8'(R_MIN)) begin
            return 9'(R_MIN);
        end else begin
            return {1'b0, r};
        end
    endfunction

    // Clamp a CIC-width signed value into the PCM range.
    function automatic logic [PCM_WIDTH-1:0] satPcm(input logic signed [CIC_WIDTH-1:0] v);
        logic signed [CIC_WIDTH-1:0] clamped;
        if (v > SAT_HI) begin
            clamped = SAT_HI;
        end else if (v < SAT_LO) begin
            clamped = SAT_LO;
        end else begin
            clamped = v;
        end
        return clamped[PCM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sd_decimator_cic_integrator.sv
// Single CIC integrator stage: a wrapping accumulator that adds din on
// every enabled cycle.
//   clock    - rising-edge clock
//   reset_n  - synchronous active-low reset, clears the accumulator
//   enable   - 1 = accumulate this cycle, 0 = hold
//   din      - addend (two's complement, CIC width)
//   acc      - registered accumulator value
//   accNext  - acc + din, the value acc takes at the next enabled edge
module cic_integrator
    import sd_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [CIC_WIDTH-1:0] din,
    output logic [CIC_WIDTH-1:0] acc,
    output logic [CIC_WIDTH-1:0] accNext
);

    // Modular arithmetic: overflow wraps, which the comb stages undo.
    assign accNext = acc + din;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (enable) begin
            acc <= accNext;
        end
    end

endmodule

// File: rtl/sd_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream.
//   clock        - sole clock, rising edge
//   reset_n      - synchronous active-low reset
//   bitIn        - sigma-delta bit, 1 -> +1, 0 -> -1
//   enable       - consume bitIn this cycle (freezes integrators/counter when 0)
//   decimRatio   - decimation ratio R (0 = 256, 1..3 clamp to 4)
//   outShift     - arithmetic right shift applied to the comb result
//   pcmReady     - downstream accepts pcmOut this cycle
//   overrunClear - clears the sticky overrun flag
//   pcmOut       - signed 24-bit decimated sample
//   pcmValid     - pcmOut holds an untransferred sample
//   overrun      - sticky, a finished sample was dropped
// Handshake: a sample transfers in any cycle where pcmValid and pcmReady are
// both 1; pcmOut/pcmValid are held stable until that happens.
module sd_decimator
    import sd_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 bitIn,
    input  logic                 enable,
    input  logic [7:0]           decimRatio,
    input  logic [4:0]           outShift,
    input  logic                 pcmReady,
    input  logic                 overrunClear,
    output logic [PCM_WIDTH-1:0] pcmOut,
    output logic                 pcmValid,
    output logic                 overrun
);

    logic [CIC_WIDTH-1:0] xIn;
    logic [CIC_WIDTH-1:0] i1, i2, i3;
    logic [CIC_WIDTH-1:0] i1Next, i2Next, i3Next;

    assign xIn = bitIn ? CIC_WIDTH'(1) : {CIC_WIDTH{1'b1}};

    // Each stage adds the previous stage's registered value.
    cic_integrator u_int1 (.clock(clock), .reset_n(reset_n), .enable(enable),
                           .din(xIn), .acc(i1), .accNext(i1Next));
    cic_integrator u_int2 (.clock(clock), .reset_n(reset_n), .enable(enable),
                           .din(i1), .acc(i2), .accNext(i2Next));
    cic_integrator u_int3 (.clock(clock), .reset_n(reset_n), .enable(enable),
                           .din(i2), .acc(i3), .accNext(i3Next));

    // Decimation counter and frame ratio
    logic [7:0] decimCount;
    logic [8:0] rLatch;
    logic       tick;

    assign tick = enable && ({1'b0, decimCount} == (rLatch - 9'd1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            decimCount <= '0;
            rLatch     <= effRatio(decimRatio);
        end else if (enable) begin
            if (tick) begin
                decimCount <= '0;
                rLatch     <= effRatio(decimRatio);
            end else begin
                decimCount <= decimCount + 8'd1;
            end
        end
    end

    // Comb sequencer. Ticks are at least R_MIN cycles apart, so a new tick
    // can only coincide with IDLE or OUT, never with C1..C3.
    seqState_t            seqState;
    logic [CIC_WIDTH-1:0] combIn, sD, c1, c1D, c2, c2D, c3;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seqState <= SEQ_IDLE;
            combIn   <= '0;
            sD       <= '0;
            c1       <= '0;
            c1D      <= '0;
            c2       <= '0;
            c2D      <= '0;
            c3       <= '0;
        end else begin
            case (seqState)
                SEQ_IDLE: begin
                    if (tick) begin
                        combIn   <= i3Next;
                        seqState <= SEQ_C1;
                    end
                end
                SEQ_C1: begin
                    c1       <= combIn - sD;
                    sD       <= combIn;
                    seqState <= SEQ_C2;
                end
                SEQ_C2: begin
                    c2       <= c1 - c1D;
                    c1D      <= c1;
                    seqState <= SEQ_C3;
                end
                SEQ_C3: begin
                    c3       <= c2 - c2D;
                    c2D      <= c2;
                    seqState <= SEQ_OUT;
                end
                SEQ_OUT: begin
                    if (tick) begin
                        combIn   <= i3Next;
                        seqState <= SEQ_C1;
                    end else begin
                        seqState <= SEQ_IDLE;
                    end
                end
                default: seqState <= SEQ_IDLE;
            endcase
        end
    end

    // Output stage
    logic signed [CIC_WIDTH-1:0] shifted;
    logic [1:0]                  warmCount;
    logic                        outStrobe;
    logic                        dropSample;
    logic                        loadSample;

    assign shifted = $signed(c3) >>> outShift;
    // The first two frames only fill the comb delay history.
    assign outStrobe  = (seqState == SEQ_OUT) && (warmCount == 2'd2);
    assign dropSample = outStrobe && pcmValid && !pcmReady;
    assign loadSample = outStrobe && !dropSample;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            warmCount <= '0;
            pcmOut    <= '0;
            pcmValid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if ((seqState == SEQ_OUT) && (warmCount != 2'd2)) begin
                warmCount <= warmCount + 2'd1;
            end
            if (loadSample) begin
                pcmOut   <= satPcm(shifted);
                pcmValid <= 1'b1;
            end else if (pcmValid && pcmReady) begin
                pcmValid <= 1'b0;
            end
            // Setting takes priority over a simultaneous clear.
            if (dropSample) begin
                overrun <= 1'b1;
            end else if (overrunClear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_decimator.sv
module tb_sd_decimator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        bitIn;
  logic        enable;
  logic [7:0]  decimRatio;
  logic [4:0]  outShift;
  logic        pcmReady;
  logic        overrunClear;
  logic [23:0] pcmOut;
  logic        pcmValid;
  logic        overrun;

  sd_decimator dut (
    .clock(clock), .reset_n(reset_n), .bitIn(bitIn), .enable(enable),
    .decimRatio(decimRatio), .outShift(outShift), .pcmReady(pcmReady),
    .overrunClear(overrunClear), .pcmOut(pcmOut), .pcmValid(pcmValid),
    .overrun(overrun)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    int          pat;     // 0 = const 0, 1 = const 1, 2 = alternating 1,0
    logic [7:0]  ratio;
    logic [4:0]  shift;
    bit          rand_en;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[13];

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    overrunClear = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_for(input int pat, input int n);
    if (pat == 0) return 1'b0;
    if (pat == 1) return 1'b1;
    return (n % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    logic early;
    reset_n = 1'b0; bitIn = 1'b0; enable = 1'b0; decimRatio = 8'd4;
    outShift = 5'd0; pcmReady = 1'b1; overrunClear = 1'b0;

    vecs[0]  = '{1, 8'd4,   5'd0, 1'b0, 24'd64};
    vecs[1]  = '{1, 8'd3,   5'd0, 1'b0, 24'd64};
    vecs[2]  = '{0, 8'd4,   5'd0, 1'b0, 24'hFFFFC0};
    vecs[3]  = '{2, 8'd4,   5'd0, 1'b0, 24'd0};
    vecs[4]  = '{1, 8'd4,   5'd0, 1'b1, 24'd64};
    vecs[5]  = '{1, 8'd8,   5'd0, 1'b0, 24'd512};
    vecs[6]  = '{1, 8'd16,  5'd3, 1'b0, 24'd512};
    vecs[7]  = '{1, 8'd0,   5'd0, 1'b0, 24'h7FFFFF};
    vecs[8]  = '{1, 8'd0,   5'd1, 1'b0, 24'h7FFFFF};
    vecs[9]  = '{1, 8'd0,   5'd2, 1'b0, 24'h400000};
    vecs[10] = '{0, 8'd0,   5'd0, 1'b0, 24'h800000};
    vecs[11] = '{2, 8'd8,   5'd0, 1'b0, 24'd0};
    vecs[12] = '{0, 8'd1,   5'd2, 1'b0, 24'hFFFFF0};

    // table-driven steady-state vectors with scoreboard
    for (int v = 0; v < 13; v++) begin
      int n_bits;
      int got;
      int cyc;
      decimRatio = vecs[v].ratio;
      outShift = vecs[v].shift;
      pcmReady = 1'b1;
      do_reset();
      check($sformatf("v%0d_reset_out", v), pcmOut, 24'd0);
      for (int k = 0; k < 3; k++) exp_q.push_back(vecs[v].exp);
      n_bits = 0; got = 0; cyc = 0;
      while (got < 3 && cyc < 4000) begin
        if (pcmValid) begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check($sformatf("v%0d_sample%0d", v, got), pcmOut, e);
          got++;
        end
        enable = vecs[v].rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (enable) begin
          bitIn = bit_for(vecs[v].pat, n_bits);
          n_bits++;
        end
        next_cycle();
        cyc++;
      end
      if (got < 3) begin
        n_cmp++; n_fail++;
        $display("FAIL v%0d_timeout: got %0d samples expected 3", v, got);
        exp_q.delete();
      end
    end

    // timing and mid-frame ratio change
    decimRatio = 8'd4; outShift = 5'd0; pcmReady = 1'b1; bitIn = 1'b1;
    do_reset();
    enable = 1'b1;
    early = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      next_cycle();
      if (c == 13) decimRatio = 8'd8;
      if (c < 16 && pcmValid) early = 1'b1;
      if (c == 16) begin
        check("t_valid_c16", 24'(pcmValid), 24'd1);
        check("t_out_c16", pcmOut, 24'd64);
      end
      if (c == 15) check("t_valid_c15", 24'(pcmValid), 24'd0);
      if (c == 17) check("t_valid_c17", 24'(pcmValid), 24'd0);
      if (c == 20) check("t_valid_c20", 24'(pcmValid), 24'd1);
      if (c == 24) check("t_ratio_c24", 24'(pcmValid), 24'd0);
      if (c == 28) check("t_ratio_c28", 24'(pcmValid), 24'd1);
    end
    check("t_warmup_suppressed", 24'(early), 24'd0);

    // overrun / hold / clear / coincident transfer
    decimRatio = 8'd4; pcmReady = 1'b0; bitIn = 1'b1;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      next_cycle();
      case (c)
        16: begin
          check("o_valid_c16", 24'(pcmValid), 24'd1);
          check("o_out_c16", pcmOut, 24'd64);
        end
        19: check("o_ovr_c19", 24'(overrun), 24'd0);
        20: begin
          check("o_ovr_c20", 24'(overrun), 24'd1);
          check("o_valid_c20", 24'(pcmValid), 24'd1);
          check("o_out_c20", pcmOut, 24'd64);
        end
        21: overrunClear = 1'b1;
        22: begin
          overrunClear = 1'b0;
          check("o_clear_c22", 24'(overrun), 24'd0);
        end
        23: overrunClear = 1'b1;
        24: begin
          overrunClear = 1'b0;
          check("o_setwins_c24", 24'(overrun), 24'd1);
          check("o_out_c24", pcmOut, 24'd64);
        end
        25: pcmReady = 1'b1;
        26: begin
          pcmReady = 1'b0;
          check("o_xfer_c26", 24'(pcmValid), 24'd0);
        end
        28: check("o_valid_c28", 24'(pcmValid), 24'd1);
        29: overrunClear = 1'b1;
        30: begin
          overrunClear = 1'b0;
          check("o_clear_c30", 24'(overrun), 24'd0);
        end
        31: pcmReady = 1'b1;
        32: begin
          check("o_coinc_valid_c32", 24'(pcmValid), 24'd1);
          check("o_coinc_ovr_c32", 24'(overrun), 24'd0);
          check("o_coinc_out_c32", pcmOut, 24'd64);
        end
        33: check("o_valid_c33", 24'(pcmValid), 24'd0);
        default: ;
      endcase
    end

    // reset in the middle of the comb sequence (C2 in cycle 21)
    decimRatio = 8'd4; pcmReady = 1'b0; bitIn = 1'b1;
    do_reset();
    enable = 1'b1;
    early = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      next_cycle();
      if (c == 20) check("r_ovr_before", 24'(overrun), 24'd1);
      if (c == 21) reset_n = 1'b0;
      if (c == 22) begin
        check("r_out_zero", pcmOut, 24'd0);
        check("r_valid_zero", 24'(pcmValid), 24'd0);
        check("r_ovr_zero", 24'(overrun), 24'd0);
        reset_n = 1'b1;
        pcmReady = 1'b1;
      end
      if (c > 22 && c < 38 && pcmValid) early = 1'b1;
      if (c == 38) begin
        check("r_valid_c38", 24'(pcmValid), 24'd1);
        check("r_out_c38", pcmOut, 24'd64);
      end
    end
    check("r_warmup_again", 24'(early), 24'd0);

    // enable dropped after the tick does not stall the comb sequence
    decimRatio = 8'd4; pcmReady = 1'b1; bitIn = 1'b1;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (c == 12) enable = 1'b0;
      if (c == 16) begin
        check("e_valid_c16", 24'(pcmValid), 24'd1);
        check("e_out_c16", pcmOut, 24'd64);
      end
    end

    // final report
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
